pcs_scrambler_hs: RTL and testbench
===================================

Name: pcs_scrambler_hs

Overview:
- Self-synchronous 64b/66b scrambler/descrambler, G(x) = 1 + x^39 + x^58 (IEEE 802.3 cl.49.2), with full valid/ready backpressure.
- Sits between the 64b/66b encoder and the gearbox (TX), or between the gearbox and the decoder (RX).
- Successor to the single-mode scrambler, adding:
  - runtime scramble/descramble mode
  - per-beat sync-header bypass
  - a skid buffer, so upstream ready is registered while throughput stays at one beat per cycle.

Parameters:
- DATA_WIDTH, 32, beat width in bits; legal values 16..66.
- HDR_WIDTH, 2, number of sync-header bits passed through unscrambled on header beats; must be < DATA_WIDTH.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset; synchronous, active-low.
- i_mode  in  1  0 = scramble, 1 = descramble; sampled per accepted beat.
- i_rx_data  in  DATA_WIDTH  input beat; bit 0 is transmitted first.
- i_rx_hdr  in  1  beat carries a sync header in bits [HDR_WIDTH-1:0].
- i_rx_data_valid  in  1  input beat valid.
- o_tx_trdy  out  1  ready to upstream; registered.
- o_tx_data  out  DATA_WIDTH  output beat.
- o_tx_hdr  out  1  i_rx_hdr delayed alongside its data.
- o_tx_data_valid  out  1  output beat valid.
- i_rx_trdy  in  1  ready from downstream.

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - lfsr = all ones (58'h3FF_FFFF_FFFF_FFFF)
  - skid buffer and output register empty
  - o_tx_data_valid = 0, o_tx_data = 0, o_tx_hdr = 0, o_tx_trdy = 1
  - Reset mid-stream discards all held beats; no partial beat is emitted.
- Accept: a beat is accepted when i_rx_data_valid && o_tx_trdy. The LFSR advances only on an accepted beat. Valid without ready, or ready without valid, leaves the state unchanged.
- Bit processing, for i = 0..DATA_WIDTH-1:
  - Header-bypass bits (i_rx_hdr = 1 and i < HDR_WIDTH):
    - out[i] = in[i].
    - The LFSR does not shift for these bits.
  - All other bits, fb = lfsr[38] ^ lfsr[57]:
    - out[i] = in[i] ^ fb.
    - Scramble: shift out[i] into lfsr[0].
    - Descramble: shift in[i] into lfsr[0].
  - LFSR shift per beat = DATA_WIDTH on normal beats, DATA_WIDTH - HDR_WIDTH on header beats.
  - The mode may change between beats. The LFSR is shared, so a descrambler self-resynchronises within 58 bits.
- Output register and skid buffer:
  - Output register: holds the presented beat.
  - Skid buffer: one entry.
    - Fills when a beat is accepted while the output register is valid and i_rx_trdy = 0.
  - o_tx_trdy <= ~skid_full_next.
  - Latency: accepted beat appears on o_tx_data exactly 1 cycle later when the output register is empty or draining.
  - Throughput: 1 beat/clk with i_rx_trdy held high.
  - Output stability: o_tx_data and o_tx_hdr are stable while o_tx_data_valid && !i_rx_trdy.
  - Beats are never dropped or duplicated. Order is preserved.
- Simultaneous drain + accept: the output register takes the skid entry if present, else the new beat. The skid entry is then refilled by the new beat or cleared.
- Full: skid full implies o_tx_trdy = 0 on the next cycle. It deasserts no earlier than the cycle after the downstream drain.

Optional Feature:
- Macro SCRAMBLER_SEED_LOAD_EN.
- When defined, two ports are added:
  - i_seed_load  in  1
  - i_seed  in  58
- Behaviour with the macro:
  - When i_seed_load is high at a clock edge (not in reset), lfsr <= i_seed.
  - Load takes priority over an LFSR advance in the same cycle; the beat accepted that cycle uses the pre-load lfsr for its data.
  - Held beats are unaffected.
- Without the macro: the ports are absent and the LFSR is only ever reset to all ones.

Test Plan:
- Scramble, DATA_WIDTH=32, i_mode=0, i_rx_hdr=0, three beats of 0x00000000 after reset, i_rx_trdy=1 -> outputs 0x00000000, then 0x03FFFF80, one beat per cycle, each 1 cycle after accept.
- Loopback: scrambler output feeds a second instance with i_mode=1, 200 random beats -> data bit-exact after the first 2 beats, even with mismatched reset seeds.
- Header bypass: i_rx_hdr=1, in=0x00000001, HDR_WIDTH=2 -> o_tx_data[1:0]=2'b01, o_tx_hdr=1. The next non-header beat matches a golden model advanced by 30 bits, not 32.
- Backpressure:
  - Stimulus: constant valid, random i_rx_trdy (50%), 500 beats.
  - Required: no loss or duplication.
  - Required: o_tx_data is stable while stalled.
  - Required: o_tx_trdy falls only when the skid buffer is full.
- Reset mid-stream: assert i_reset_n=0 for 1 cycle with the skid full -> next cycle o_tx_data_valid=0, o_tx_trdy=1. The first post-reset beat of zeros gives 0x00000000.
- SCRAMBLER_SEED_LOAD_EN: load i_seed = 58'h0 and scramble 0x00000000 -> output 0x00000000 indefinitely. Load and accept in the same cycle -> that beat uses the old lfsr.

Source files
------------

// File: rtl/pcs_scrambler_hs.sv
// pcs_scrambler_hs: self-synchronous 64b/66b scrambler/descrambler (1+x^39+x^58) with skid buffer; define SCRAMBLER_SEED_LOAD_EN to add runtime LFSR seed load
module pcs_scrambler_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_mode,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_hdr,
  input  logic                  i_rx_data_valid,
  output logic                  o_tx_trdy,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_hdr,
  output logic                  o_tx_data_valid,
  input  logic                  i_rx_trdy
`ifdef SCRAMBLER_SEED_LOAD_EN
  ,
  input  logic                  i_seed_load,
  input  logic [57:0]           i_seed
`endif
);
  logic [57:0]           lfsr, lfsr_next;
  logic [DATA_WIDTH-1:0] scr_data, skid_data;
  logic                  skid_hdr, skid_valid, skid_next, accept, load_out, to_skid;
  assign accept   = i_rx_data_valid && o_tx_trdy;
  assign load_out = !o_tx_data_valid || i_rx_trdy;
  assign skid_next = load_out ? skid_valid && accept : skid_valid || accept;
  assign to_skid  = accept && (!load_out || skid_valid);
  // Bit-serial scramble of one beat, bit 0 first; header bits bypass without shifting the LFSR
  always_comb begin
    lfsr_next = lfsr;
    scr_data  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i_rx_hdr && i < HDR_WIDTH) scr_data[i] = i_rx_data[i];
      else begin
        scr_data[i] = i_rx_data[i] ^ lfsr_next[38] ^ lfsr_next[57];
        lfsr_next   = {lfsr_next[56:0], i_mode ? i_rx_data[i] : scr_data[i]};
      end
    end
  end
  // LFSR advances only on accepted beats; a seed load overrides that advance
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) lfsr <= '1;
`ifdef SCRAMBLER_SEED_LOAD_EN
    else if (i_seed_load) lfsr <= i_seed;
`endif
    else if (accept) lfsr <= lfsr_next;
  end
  // Output register plus one-entry skid so upstream ready can be registered
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_tx_data_valid <= 1'b0;
      o_tx_data       <= '0;
      o_tx_hdr        <= 1'b0;
      skid_valid      <= 1'b0;
      skid_data       <= '0;
      skid_hdr        <= 1'b0;
      o_tx_trdy       <= 1'b1;
    end else begin
      if (load_out) begin
        o_tx_data_valid <= skid_valid || accept;
        if (skid_valid) begin
          o_tx_data <= skid_data;
          o_tx_hdr  <= skid_hdr;
        end else if (accept) begin
          o_tx_data <= scr_data;
          o_tx_hdr  <= i_rx_hdr;
        end
      end
      if (to_skid) begin
        skid_data <= scr_data;
        skid_hdr  <= i_rx_hdr;
      end
      skid_valid <= skid_next;
      o_tx_trdy  <= !skid_next;
    end
  end
endmodule

// File: tb/tb_pcs_scrambler_hs.sv
// tb_pcs_scrambler_hs: directed checks of pcs_scrambler_hs with a bit-serial reference model
module tb_pcs_scrambler_hs;
  logic        clk = 1'b0;
  logic        rst_n, rst_rx_n, mode, hdr, vld, rx_trdy;
  logic [31:0] din;
  logic        trdy, ohdr, ovld;
  logic [31:0] dout;
  logic [31:0] lb_data;
  logic        lb_hdr, lb_vld, lb_trdy;
`ifdef SCRAMBLER_SEED_LOAD_EN
  logic        seed_load;
  logic [57:0] seed;
`endif
  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  pcs_scrambler_hs #(.DATA_WIDTH(32), .HDR_WIDTH(2)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_mode(mode), .i_rx_data(din), .i_rx_hdr(hdr),
    .i_rx_data_valid(vld), .o_tx_trdy(trdy), .o_tx_data(dout), .o_tx_hdr(ohdr),
    .o_tx_data_valid(ovld), .i_rx_trdy(rx_trdy)
`ifdef SCRAMBLER_SEED_LOAD_EN
    , .i_seed_load(seed_load), .i_seed(seed)
`endif
  );

  pcs_scrambler_hs #(.DATA_WIDTH(32), .HDR_WIDTH(2)) u_rx (
    .i_clk(clk), .i_reset_n(rst_rx_n), .i_mode(1'b1), .i_rx_data(dout), .i_rx_hdr(ohdr),
    .i_rx_data_valid(ovld && rx_trdy), .o_tx_trdy(lb_trdy), .o_tx_data(lb_data), .o_tx_hdr(lb_hdr),
    .o_tx_data_valid(lb_vld), .i_rx_trdy(1'b1)
`ifdef SCRAMBLER_SEED_LOAD_EN
    , .i_seed_load(1'b0), .i_seed(58'h0)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [89:0] model(input logic [57:0] s, input logic [31:0] d, input logic h, input logic m);
    logic [31:0] o;
    logic        b;
    o = d;
    for (int i = 0; i < 32; i++) begin
      if (!(h && i < 2)) begin
        b    = s[38] ^ s[57];
        o[i] = d[i] ^ b;
        s    = {s[56:0], m ? d[i] : o[i]};
      end
    end
    return {s, o};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [57:0]  m;
    logic [89:0]  r;
    logic [32:0]  q[$];
    logic [31:0]  lq[$];
    logic [31:0]  held, exp;
    logic         acc, drn, stall;
    int           n_acc, cyc, sent, got;
    rst_n = 0; rst_rx_n = 0; mode = 0; hdr = 0; vld = 0; din = '0; rx_trdy = 1;
`ifdef SCRAMBLER_SEED_LOAD_EN
    seed_load = 0; seed = '0;
`endif
    tick; tick;
    check("rst_vld", ovld, 0);
    check("rst_data", dout, 0);
    check("rst_hdr", ohdr, 0);
    check("rst_trdy", trdy, 1);
    rst_n = 1; rst_rx_n = 1;
    vld = 1; din = 32'h0;
    tick;
    check("scr0", dout, 32'h0000_0000);
    check("scr0_vld", ovld, 1);
    tick;
    check("scr1", dout, 32'h03FF_FF80);
    tick;
    check("scr2", dout, 32'hFFFF_C000);
    vld = 0;
    tick;
    check("idle_vld", ovld, 0);
    rst_n = 0; tick; rst_n = 1;
    hdr = 1; din = 32'h1; vld = 1;
    tick;
    check("hdr_data", dout, 32'h0000_0001);
    check("hdr_flag", ohdr, 1);
    hdr = 0; din = 32'h0;
    tick;
    check("hdr_next", dout, 32'h0FFF_FE00);
    check("hdr_next_flag", ohdr, 0);
    vld = 0;
    tick;
    rst_n = 0; tick; rst_n = 1;
    rx_trdy = 0; vld = 1; din = 32'hA5A5_A5A5;
    tick;
    check("stall_trdy0", trdy, 1);
    check("stall_vld", ovld, 1);
    din = 32'h0;
    tick;
    check("stall_trdy1", trdy, 0);
    check("stall_data", dout, 32'hA5A5_A5A5);
    rst_n = 0;
    tick;
    check("mid_rst_vld", ovld, 0);
    check("mid_rst_trdy", trdy, 1);
    rst_n = 1; rx_trdy = 1; din = 32'h0; vld = 1;
    tick;
    check("post_rst_data", dout, 32'h0);
    check("post_rst_vld", ovld, 1);
    vld = 0;
    tick;
    rst_n = 0; tick; rst_n = 1;
    q.delete(); m = '1; n_acc = 0; cyc = 0;
    while ((n_acc < 500 || q.size() > 0) && cyc < 5000) begin
      vld = n_acc < 500;
      din = $urandom;
      hdr = 1'($urandom_range(0, 1));
      rx_trdy = (n_acc < 500) ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = vld && trdy;
      drn = ovld && rx_trdy;
      stall = ovld && !rx_trdy;
      held = dout;
      if (drn) begin
        if (q.size() == 0) check("bp_extra_beat", ovld, 0);
        else begin
          check("bp_data", dout, q[0][31:0]);
          check("bp_hdr", ohdr, q[0][32]);
          void'(q.pop_front());
        end
      end
      if (acc) begin
        r = model(m, din, hdr, 1'b0);
        m = r[89:32];
        q.push_back({hdr, r[31:0]});
        n_acc++;
      end
      tick;
      cyc++;
      if (stall) check("bp_stable", dout, held);
      check("bp_trdy", trdy, q.size() < 2);
      check("bp_vld", ovld, q.size() > 0);
    end
    check("bp_count", n_acc, 500);
    check("bp_empty", q.size(), 0);
    vld = 0; hdr = 0; rx_trdy = 1;
    tick; tick;
    rst_n = 0; tick; rst_n = 1;
    lq.delete(); sent = 0; got = 0; cyc = 0;
    while (got < 200 && cyc < 1000) begin
      vld = sent < 200;
      din = $urandom;
      if (vld && trdy) begin
        lq.push_back(din);
        sent++;
      end
      tick;
      cyc++;
      if (lb_vld) begin
        if (lq.size() == 0) check("lb_extra_beat", lb_vld, 0);
        else begin
          exp = lq.pop_front();
          if (got >= 2) check("lb_data", lb_data, exp);
          got++;
        end
      end
    end
    check("lb_count", got, 200);
    check("lb_trdy", lb_trdy, 1);
    vld = 0;
    tick;
`ifdef SCRAMBLER_SEED_LOAD_EN
    rst_n = 0; tick; rst_n = 1;
    vld = 1; din = 32'h0;
    tick;
    check("seed_pre", dout, 32'h0);
    seed_load = 1; seed = 58'h0;
    tick;
    check("seed_same_cycle", dout, 32'h03FF_FF80);
    seed_load = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("seed_zero", dout, 32'h0);
    end
    vld = 0;
    tick;
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
